// File: rtl/rv32i_bus_arb_pkg.sv
// Shared types and constants for the two-master RV32I memory bus arbiter.
//   arb_state_t : arbiter FSM states
//   master_id_t : 1-bit master identifier (M0 = core, M1 = loader/DMA)
//   bus_op_t    : decoded operation of a granted transaction
//   RD_CNT_W    : width of the read-latency down-counter
//   decode_op   : maps a master's wren/rden pair to a bus_op_t
package rv32i_bus_arb_pkg;

    localparam int RD_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef logic master_id_t;
    localparam master_id_t M0 = 1'b0;
    localparam master_id_t M1 = 1'b1;

    typedef enum logic [1:0] {
        OP_NULL  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } bus_op_t;

    // Write has priority over read when a master raises both strobes.
    function automatic bus_op_t decode_op(input logic wren, input logic rden);
        bus_op_t op;
        op = OP_NULL;
        if (wren) begin
            op = OP_WRITE;
        end else if (rden) begin
            op = OP_READ;
        end
        return op;
    endfunction

endpackage

// File: rtl/rr_picker2.sv
// Two-input round-robin picker (purely combinational).
//   req[1:0]   : request vector, bit i = master i
//   last_grant : master that won the previous arbitration
//   valid      : at least one request is present
//   winner     : chosen master; on a tie the one that did not win last time
module rr_picker2
    import rv32i_bus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_t last_grant,
    output logic       valid,
    output master_id_t winner
);

    always_comb begin
        valid = |req;
        if (&req) begin
            winner = master_id_t'(~last_grant);
        end else begin
            // Single requester (or none): bit 1 set means M1, otherwise M0.
            winner = master_id_t'(req[1]);
        end
    end

endmodule

// File: rtl/rv32i_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the RV32I core (m0)
// and a loader/DMA port (m1). One transaction is outstanding at a time and
// each access runs IDLE -> ACCESS -> [WAIT_RD] -> RESP -> IDLE.
//   clk, rst                  : clock, asynchronous active-low reset
//   mN_req/addr/wrdata/wren/rden : master N request side (held until ack)
//   mN_ack, mN_rddata         : one-cycle completion pulse and read data
//   mem_addr/wrdata/wren/rden : memory request side, live only in ACCESS
//   mem_rddata                : memory read data, valid RD_LATENCY cycles
//                               after the read strobe
//   busy                      : arbiter is not in IDLE
module rv32i_bus_arbiter
    import rv32i_bus_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wrdata,
    input  logic              m0_wren,
    input  logic              m0_rden,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rddata,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wrdata,
    input  logic              m1_wren,
    input  logic              m1_rden,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rddata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wrdata,
    output logic              mem_wren,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_rddata,

    output logic              busy
);

    localparam logic [RD_CNT_W-1:0] RD_CNT_INIT = RD_CNT_W'(RD_LATENCY - 1);

    arb_state_t           state_q;
    master_id_t           grant_q;
    master_id_t           last_grant_q;
    bus_op_t              op_q;
    logic [RD_CNT_W-1:0]  rd_cnt_q;
    logic [DATA_W-1:0]    rddata_q;
    // The memory-side address/data registers double as the grant-time
    // capture: they are loaded at grant, presented during ACCESS and cleared
    // afterwards, so later changes on the master ports are never seen.
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wrdata_q;
    logic                 mem_wren_q;
    logic                 mem_rden_q;
    logic                 m0_ack_q;
    logic                 m1_ack_q;

    logic                 pick_valid;
    master_id_t           pick_winner;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wrdata;
    bus_op_t              win_op;

    rr_picker2 u_picker (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Request fields of whichever master the picker selected.
    always_comb begin
        if (pick_winner == M1) begin
            win_addr   = m1_addr;
            win_wrdata = m1_wrdata;
            win_op     = decode_op(m1_wren, m1_rden);
        end else begin
            win_addr   = m0_addr;
            win_wrdata = m0_wrdata;
            win_op     = decode_op(m0_wren, m0_rden);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= M0;
            last_grant_q <= M1;
            op_q         <= OP_NULL;
            rd_cnt_q     <= '0;
            rddata_q     <= '0;
            mem_addr_q   <= '0;
            mem_wrdata_q <= '0;
            mem_wren_q   <= 1'b0;
            mem_rden_q   <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
        end else begin
            // Strobes, memory outputs and acks are single-cycle; only the
            // state that enters ACCESS or RESP re-asserts them.
            mem_addr_q   <= '0;
            mem_wrdata_q <= '0;
            mem_wren_q   <= 1'b0;
            mem_rden_q   <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q      <= pick_winner;
                        last_grant_q <= pick_winner;
                        op_q         <= win_op;
                        mem_addr_q   <= win_addr;
                        mem_wrdata_q <= win_wrdata;
                        mem_wren_q   <= (win_op == OP_WRITE);
                        mem_rden_q   <= (win_op == OP_READ);
                        state_q      <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (op_q == OP_READ) begin
                        rd_cnt_q <= RD_CNT_INIT;
                        state_q  <= WAIT_RD;
                    end else begin
                        m0_ack_q <= (grant_q == M0);
                        m1_ack_q <= (grant_q == M1);
                        state_q  <= RESP;
                    end
                end

                WAIT_RD: begin
                    if (rd_cnt_q == '0) begin
                        rddata_q <= mem_rddata;
                        m0_ack_q <= (grant_q == M0);
                        m1_ack_q <= (grant_q == M1);
                        state_q  <= RESP;
                    end else begin
                        rd_cnt_q <= rd_cnt_q - 1'b1;
                    end
                end

                RESP: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wrdata = mem_wrdata_q;
    assign mem_wren   = mem_wren_q;
    assign mem_rden   = mem_rden_q;
    assign m0_ack     = m0_ack_q;
    assign m1_ack     = m1_ack_q;
    // Read data is shared; it only has meaning alongside the matching ack.
    assign m0_rddata  = rddata_q;
    assign m1_rddata  = rddata_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rv32i_bus_arbiter.sv
// Self-checking bench for rv32i_bus_arbiter. A transaction-level model
// predicts, for every granted transfer, the grant cycle, the memory strobe
// cycle and the ack cycle by plain arithmetic, and a reference memory
// array predicts read data.
module tb_rv32i_bus_arbiter;

    localparam int L = 3;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  gap;
    } txn_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m0_wren, m0_rden, m0_ack;
    logic [31:0] m0_addr, m0_wrdata, m0_rddata;
    logic        m1_req, m1_wren, m1_rden, m1_ack;
    logic [31:0] m1_addr, m1_wrdata, m1_rddata;
    logic [31:0] mem_addr, mem_wrdata, mem_rddata;
    logic        mem_wren, mem_rden, busy;

    rv32i_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req     (m0_req),
        .m0_addr    (m0_addr),
        .m0_wrdata  (m0_wrdata),
        .m0_wren    (m0_wren),
        .m0_rden    (m0_rden),
        .m0_ack     (m0_ack),
        .m0_rddata  (m0_rddata),
        .m1_req     (m1_req),
        .m1_addr    (m1_addr),
        .m1_wrdata  (m1_wrdata),
        .m1_wren    (m1_wren),
        .m1_rden    (m1_rden),
        .m1_ack     (m1_ack),
        .m1_rddata  (m1_rddata),
        .mem_addr   (mem_addr),
        .mem_wrdata (mem_wrdata),
        .mem_wren   (mem_wren),
        .mem_rden   (mem_rden),
        .mem_rddata (mem_rddata),
        .busy       (busy)
    );

    function automatic logic [31:0] init_pat(input logic [7:0] i);
        return 32'hC0DE_0000 | {24'h0, i};
    endfunction

    // ---------------- memory environment (fixed read latency L) ----------
    logic [31:0]  env_mem [256];
    logic [255:0] env_vld = '0;
    logic [L-1:0] pv = '0;
    logic [31:0]  pd [L];

    always @(posedge clk) begin
        if (mem_wren) begin
            env_mem[mem_addr[9:2]] <= mem_wrdata;
            env_vld[mem_addr[9:2]] <= 1'b1;
        end
        pv    <= {pv[L-2:0], mem_rden};
        pd[0] <= env_vld[mem_addr[9:2]] ? env_mem[mem_addr[9:2]] : init_pat(mem_addr[9:2]);
        for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
    end
    // Garbage outside the exact data cycle exposes any latency slip.
    assign mem_rddata = pv[L-1] ? pd[L-1] : 32'hBAD0_0BAD;

    // ---------------- reference model state ------------------------------
    logic [31:0]  ref_mem [256];
    logic [255:0] ref_vld;
    txn_t         q0[$];
    txn_t         q1[$];
    txn_t         cur [2];
    logic [1:0]   act;
    int           cyc, n_vec, n_err;
    int           g_cyc, ack_cyc, g_m, g_op, last_g;
    logic [31:0]  g_addr, g_wdata, g_rd, exp_rd;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_vld[a[9:2]] ? ref_mem[a[9:2]] : init_pat(a[9:2]);
    endfunction

    function automatic txn_t rand_txn(input int max_gap);
        txn_t t;
        t.wr    = 1'($urandom_range(0, 1));
        t.rd    = 1'($urandom_range(0, 1));
        t.addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        t.wdata = $urandom;
        t.gap   = 4'($urandom_range(0, max_gap));
        return t;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive();
        m0_req    = act[0];
        m0_wren   = cur[0].wr;
        m0_rden   = cur[0].rd;
        m0_addr   = cur[0].addr;
        m0_wrdata = cur[0].wdata;
        m1_req    = act[1];
        m1_wren   = cur[1].wr;
        m1_rden   = cur[1].rd;
        m1_addr   = cur[1].addr;
        m1_wrdata = cur[1].wdata;
    endtask

    task automatic load(input int m);
        if (!act[m]) begin
            if (m == 0 && q0.size() > 0) begin
                if (q0[0].gap != 0) q0[0].gap = q0[0].gap - 4'd1;
                else begin cur[0] = q0.pop_front(); act[0] = 1'b1; end
            end
            if (m == 1 && q1.size() > 0) begin
                if (q1[0].gap != 0) q1[0].gap = q1[0].gap - 4'd1;
                else begin cur[1] = q1.pop_front(); act[1] = 1'b1; end
            end
        end
    endtask

    // Bus is idle in this cycle and the driven requests are seen: decide
    // the winner and schedule the transaction's milestones.
    task automatic grant();
        int w;
        if (act[0] && act[1]) w = 1 - last_g;
        else                  w = act[1] ? 1 : 0;
        g_cyc   = cyc;
        g_m     = w;
        last_g  = w;
        g_op    = cur[w].wr ? 2 : (cur[w].rd ? 1 : 0);
        g_addr  = cur[w].addr;
        g_wdata = cur[w].wdata;
        ack_cyc = cyc + ((g_op == 1) ? L + 2 : 2);
        if (g_op == 1) g_rd = ref_read(g_addr);
        if (g_op == 2) begin
            ref_mem[g_addr[9:2]] = g_wdata;
            ref_vld[g_addr[9:2]] = 1'b1;
        end
        $display("txn m%0d op=%0d addr=%h wdata=%h grant@%0d ack@%0d",
                 w, g_op, g_addr, g_wdata, g_cyc, ack_cyc);
    endtask

    task automatic sample_check();
        logic acc;
        acc = (cyc == g_cyc + 1);
        chk1("busy", busy, (cyc > g_cyc) && (cyc <= ack_cyc));
        chk1("mem_wren", mem_wren, acc && (g_op == 2));
        chk1("mem_rden", mem_rden, acc && (g_op == 1));
        if (acc) begin
            if (g_op != 0) begin
                chk32("mem_addr", mem_addr, g_addr);
                chk32("mem_wrdata", mem_wrdata, g_wdata);
            end
        end else begin
            chk32("mem_addr_quiet", mem_addr, 32'h0);
            chk32("mem_wrdata_quiet", mem_wrdata, 32'h0);
        end
        chk1("m0_ack", m0_ack, (cyc == ack_cyc) && (g_m == 0));
        chk1("m1_ack", m1_ack, (cyc == ack_cyc) && (g_m == 1));
        if (cyc == ack_cyc) begin
            if (g_op == 1) exp_rd = g_rd;
            chk32("m0_rddata", m0_rddata, exp_rd);
            chk32("m1_rddata", m1_rddata, exp_rd);
        end
    endtask

    task automatic engine(input int max_cyc);
        int   start;
        logic done;
        start = cyc;
        done  = 1'b0;
        while (!done && (cyc - start) <= max_cyc) begin
            tick();
            sample_check();
            if (cyc == ack_cyc) act[g_m] = 1'b0;
            // Post-grant change of the granted master's address/data.
            if (cyc == g_cyc + 1) begin
                cur[g_m].addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
                cur[g_m].wdata = $urandom;
            end
            load(0);
            load(1);
            drive();
            if (cyc > ack_cyc && act != 2'b00) grant();
            if (act == 2'b00 && q0.size() == 0 && q1.size() == 0 && cyc > ack_cyc)
                done = 1'b1;
        end
        chk1("engine_drain", done, 1'b1);
    endtask

    task automatic model_reset();
        g_cyc   = -100;
        ack_cyc = -100;
        g_m     = 0;
        g_op    = 0;
        last_g  = 1;
        exp_rd  = 32'h0;
    endtask

    initial begin
        rst = 1'b0;
        act = 2'b00;
        cur[0] = '0;
        cur[1] = '0;
        ref_vld = '0;
        cyc = 0; n_vec = 0; n_err = 0;
        g_addr = '0; g_wdata = '0; g_rd = '0;
        model_reset();
        drive();
        tick();
        tick();

        // Reset values
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_wren", mem_wren, 1'b0);
        chk1("rst_mem_rden", mem_rden, 1'b0);
        chk1("rst_m0_ack", m0_ack, 1'b0);
        chk1("rst_m1_ack", m1_ack, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wrdata", mem_wrdata, 32'h0);
        chk32("rst_m0_rddata", m0_rddata, 32'h0);
        chk32("rst_m1_rddata", m1_rddata, 32'h0);

        // Contention: both masters requesting from reset release, 4 each.
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rand_txn(0));
            q1.push_back(rand_txn(0));
        end
        load(0);
        load(1);
        drive();
        rst = 1'b1;
        grant();
        engine(200);

        // Single write by m0
        q0.push_back('{wr: 1'b1, rd: 1'b0, addr: 32'h0000_0040, wdata: 32'hDEAD_BEEF, gap: 4'd1});
        engine(50);

        // Place a known word, then m1 reads it back with latency L
        q0.push_back('{wr: 1'b1, rd: 1'b0, addr: 32'h0000_0200, wdata: 32'h1234_5678, gap: 4'd0});
        engine(50);
        q1.push_back('{wr: 1'b0, rd: 1'b1, addr: 32'h0000_0200, wdata: 32'h0, gap: 4'd0});
        engine(50);

        // Write and read both raised: write wins, address changes after grant
        q0.push_back('{wr: 1'b1, rd: 1'b1, addr: 32'h0000_0010, wdata: 32'h0000_0005, gap: 4'd0});
        engine(50);

        // Null op: no strobe, ack at N+2, read data unchanged
        q1.push_back('{wr: 1'b0, rd: 1'b0, addr: 32'h0000_0080, wdata: 32'h5555_AAAA, gap: 4'd0});
        engine(50);

        // Read back the mixed-op write
        q1.push_back('{wr: 1'b0, rd: 1'b1, addr: 32'h0000_0010, wdata: 32'h0, gap: 4'd0});
        engine(50);

        // Randomized traffic with idle gaps
        for (int i = 0; i < 30; i++) begin
            q0.push_back(rand_txn(3));
            q1.push_back(rand_txn(3));
        end
        engine(3000);

        // Reset asserted while m0's read sits in WAIT_RD
        act[0] = 1'b1;
        cur[0] = '{wr: 1'b0, rd: 1'b1, addr: 32'h0000_0100, wdata: 32'h0, gap: 4'd0};
        drive();
        grant();
        tick();
        sample_check();
        tick();
        sample_check();
        #2 rst = 1'b0;
        #1;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_mem_rden", mem_rden, 1'b0);
        chk1("midrst_mem_wren", mem_wren, 1'b0);
        chk1("midrst_m0_ack", m0_ack, 1'b0);
        chk32("midrst_mem_addr", mem_addr, 32'h0);
        chk32("midrst_m0_rddata", m0_rddata, 32'h0);
        act[0] = 1'b0;
        drive();
        model_reset();
        repeat (L + 3) begin
            tick();
            sample_check();
        end
        rst = 1'b1;

        // After reset: rddata cleared, and m0 wins a fresh tie
        q1.push_back('{wr: 1'b0, rd: 1'b0, addr: 32'h0000_0004, wdata: 32'h0, gap: 4'd0});
        engine(50);
        q0.push_back('{wr: 1'b1, rd: 1'b0, addr: 32'h0000_0300, wdata: 32'hA5A5_0001, gap: 4'd0});
        q1.push_back('{wr: 1'b0, rd: 1'b1, addr: 32'h0000_0040, wdata: 32'h0, gap: 4'd0});
        engine(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv32i_bus_arbiter.md
Name: rv32i_bus_arbiter

Overview:
- Shares the single 32-bit memory bus between two requesters: m0 is the RV32I core (fetch, load and store) and m1 is a program loader or DMA port.
- Round-robin grant, one outstanding transaction at a time.
- Sequences each access as strobe, optional read wait, then a one-cycle ack.
- The memory side has a fixed read latency.
- Sits between the core/loader and the memory model; the core holds its request until it sees ack.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (matches RV32I_OPERAND_t)
- RD_LATENCY, 1, cycles from mem_rden strobe to valid mem_rddata; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- m0_req  in  1  m0 requests an access; held high until m0_ack
- m0_addr  in  ADDR_W  m0 address
- m0_wrdata  in  DATA_W  m0 write data
- m0_wren  in  1  m0 write
- m0_rden  in  1  m0 read
- m0_ack  out  1  one-cycle completion pulse to m0
- m0_rddata  out  DATA_W  read data; valid only while m0_ack=1
- m1_req, m1_addr, m1_wrdata, m1_wren, m1_rden, m1_ack, m1_rddata  same directions, widths and meanings as the m0 ports, for m1
- mem_addr  out  ADDR_W  memory address
- mem_wrdata  out  DATA_W  memory write data
- mem_wren  out  1  memory write strobe
- mem_rden  out  1  memory read strobe
- mem_rddata  in  DATA_W  memory read data
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; last_grant=1, so m0 wins the first tie.
  - All outputs 0; the captured addr, wrdata and rddata registers are 0.
  - Any in-flight read is discarded; no ack is issued for it.
- FSM states: IDLE, ACCESS, WAIT_RD, RESP.
- IDLE:
  - If any req is high, pick a winner, register grant_id, and capture that master's addr, wrdata and op, then go to ACCESS.
  - If only one req is high, it wins.
  - If both are high, the master not equal to last_grant wins. last_grant is updated to the winner at grant time.
  - If neither is high, stay in IDLE.
- Operation select: if wren=1 the transaction is a write, whatever rden is; else if rden=1 it is a read; else it is a null op. A null op still completes with an ack and issues no memory strobe.
- ACCESS (exactly 1 cycle):
  - mem_addr/mem_wrdata driven from the captured registers.
  - mem_wren=1 for a write, mem_rden=1 for a read.
  - Write or null op goes to RESP.
  - Read loads rd_cnt=RD_LATENCY-1 and goes to WAIT_RD.
- WAIT_RD:
  - Memory strobes are 0.
  - If rd_cnt==0, capture mem_rddata into the rddata register and go to RESP; else decrement rd_cnt.
- RESP (exactly 1 cycle):
  - ack of the granted master =1; the other master's ack =0.
  - Both mN_rddata outputs are driven from the rddata register. Write data and null ops leave it unchanged.
  - Next state is IDLE.
- Latency, with the request seen in IDLE at cycle N:
  - Memory strobe at N+1.
  - Write ack at N+2.
  - Read data sampled at N+RD_LATENCY+1; read ack at N+RD_LATENCY+2.
- Arbitration: re-arbitration happens only in IDLE, so there are no back-to-back grants without an IDLE cycle. Minimum spacing is 3 cycles per write.
- Fairness: with both masters continuously requesting, grants strictly alternate.
- Request dropped before ack: this is a protocol violation. The transaction still completes and the ack still pulses.
- Changes to mN_addr/wrdata after grant are ignored, because the values were captured at grant.
- Memory outputs are 0 in every state except ACCESS.

Decomposition:
- Shared package rv32i_bus_arb_pkg holds:
  - arb_state_t enum {IDLE, ACCESS, WAIT_RD, RESP}
  - master_id_t (1 bit: M0=0, M1=1)
  - bus_op_t enum {OP_NULL, OP_READ, OP_WRITE}
  - RD_CNT_W=4
- Sub-module rr_picker2 (combinational):
  - inputs req[1:0], last_grant
  - outputs valid, winner
  - reused by any future multi-port bus.
- FSM, capture registers and rd_cnt live in the top module.

Test Plan:
- Reset in the middle of WAIT_RD:
  - Stimulus: m0 reads 0x100, then rst=0 while in WAIT_RD.
  - Response: next edge shows state=IDLE, no m0_ack, all mem outputs 0, busy=0.
- Single write:
  - Stimulus: m0 writes addr 0x0000_0040, data 0xDEAD_BEEF at cycle N.
  - Response: mem_wren=1 with that address and data at N+1; m0_ack at N+2; m1_ack stays 0.
- Single read with RD_LATENCY=3:
  - Stimulus: m1 reads 0x200; memory returns 0x1234_5678 at the sample cycle.
  - Response: mem_rden at N+1, m1_ack at N+5, m1_rddata=0x1234_5678.
- Contention:
  - Stimulus: m0_req and m1_req both held high from reset release, each for 4 transactions.
  - Response: grant order m0, m1, m0, m1, ...; each ack goes only to its master.
- Mixed op and late change:
  - Stimulus: m0 asserts wren=1 and rden=1 to 0x10 with data 5; m0_addr changes to 0x20 at N+1.
  - Response: a write to 0x10 with data 5; mem_rden=0 throughout; ack at N+2.
- Null op:
  - Stimulus: m1_req=1 with wren=rden=0.
  - Response: no memory strobe; m1_ack at N+2; m1_rddata holds its previous value.
